plru_victim_select: RTL and testbench

Replacement-victim selector for the tree pseudo-LRU scheme used by the cache simulator. It is the read side of the PLRU tree: the LRU update block writes a way's path into the tree on each access, and this block walks the same tree in the opposite direction to name the way to evict on a miss. The block accepts one request per handshake and gives invalid ways priority over the tree. It walks one tree level per clock and returns the victim over a valid/ready response channel to the cache controller.

---
 rtl/plru_pkg.sv | 22 ++
 rtl/first_invalid_way.sv | 23 ++
 rtl/plru_victim_select.sv | 101 ++++++++++
 tb/tb_plru_victim_select.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/plru_pkg.sv
// rtl/plru_pkg.sv - shared PLRU tree definitions for the victim selector and LRU update logic
package plru_pkg;

    localparam int PLRU_A_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } plru_vs_state_t;

    // Index width needed to name one of a_size ways.
    function automatic int way_w(input int a_size);
        return $clog2(a_size);
    endfunction

    // Tree layout: children of node n are 2n+1 (bit 0 side) and 2n+2 (bit 1 side).
    function automatic int unsigned child(input int unsigned n, input logic v);
        return 2 * n + 1 + {31'd0, v};
    endfunction

endpackage

// File: rtl/first_invalid_way.sv
// rtl/first_invalid_way.sv - priority encoder returning the lowest-index invalid way
module first_invalid_way #(
    parameter int A_SIZE = 8,
    parameter int WAY_W  = 3
) (
    input  logic [A_SIZE-1:0] valid_bits,
    output logic              found,
    output logic [WAY_W-1:0]  index
);

    // Scan from the top down so the lowest invalid way is the last one written.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = A_SIZE - 1; i >= 0; i--) begin
            if (!valid_bits[i]) begin
                found = 1'b1;
                index = WAY_W'(i);
            end
        end
    end

endmodule

// File: rtl/plru_victim_select.sv
// rtl/plru_victim_select.sv - tree PLRU victim selector, one tree level per clock
module plru_victim_select
    import plru_pkg::*;
#(
    parameter  int A_SIZE = PLRU_A_SIZE,
    localparam int WAY_W  = way_w(A_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [A_SIZE-2:0] lru_bits,
    input  logic [A_SIZE-1:0] valid_bits,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WAY_W-1:0]  victim,
    output logic              victim_invalid
);

    plru_vs_state_t    state;
    logic [A_SIZE-2:0] lru_q;
    logic [WAY_W-1:0]  node_q;
    logic [WAY_W-1:0]  level_q;
    logic [WAY_W-1:0]  victim_q;
    logic              victim_invalid_q;

    logic              inv_found;
    logic [WAY_W-1:0]  inv_index;
    logic              walk_bit;
    logic [WAY_W-1:0]  bit_pos;
    logic              last_level;

    // Invalid ways are decided on the request inputs in the accept cycle itself.
    first_invalid_way #(
        .A_SIZE (A_SIZE),
        .WAY_W  (WAY_W)
    ) u_first_invalid_way (
        .valid_bits (valid_bits),
        .found      (inv_found),
        .index      (inv_index)
    );

    // Walk away from the MRU side; victim bits are filled MSB first.
    always_comb begin
        walk_bit   = ~lru_q[node_q];
        bit_pos    = WAY_W'(WAY_W - 1) - level_q;
        last_level = (level_q == WAY_W'(WAY_W - 1));
    end

    // Request/walk/response sequencing with all outputs held in registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            lru_q            <= '0;
            node_q           <= '0;
            level_q          <= '0;
            victim_q         <= '0;
            victim_invalid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lru_q   <= lru_bits;
                        node_q  <= '0;
                        level_q <= '0;
                        if (inv_found) begin
                            victim_q         <= inv_index;
                            victim_invalid_q <= 1'b1;
                            state            <= DONE;
                        end else begin
                            victim_q         <= '0;
                            victim_invalid_q <= 1'b0;
                            state            <= WALK;
                        end
                    end
                end
                WALK: begin
                    victim_q <= victim_q | (WAY_W'(walk_bit) << bit_pos);
                    node_q   <= WAY_W'(child(32'(node_q), walk_bit));
                    if (last_level) begin
                        state <= DONE;
                    end else begin
                        level_q <= level_q + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready      = (state == IDLE);
    assign rsp_valid      = (state == DONE);
    assign victim         = victim_q;
    assign victim_invalid = victim_invalid_q;

endmodule

// File: tb/tb_plru_victim_select.sv
// tb/tb_plru_victim_select.sv - directed self-checking bench for plru_victim_select
module tb_plru_victim_select;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] lru_bits;
    logic [7:0] valid_bits;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [2:0] victim;
    logic       victim_invalid;

    logic       req_valid2;
    logic       req_ready2;
    logic [0:0] lru_bits2;
    logic [1:0] valid_bits2;
    logic       rsp_valid2;
    logic       rsp_ready2;
    logic [0:0] victim2;
    logic       victim_invalid2;

    int errors = 0;
    int checks = 0;

    plru_victim_select #(.A_SIZE(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .lru_bits       (lru_bits),
        .valid_bits     (valid_bits),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .victim         (victim),
        .victim_invalid (victim_invalid)
    );

    plru_victim_select #(.A_SIZE(2)) dut2 (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid2),
        .req_ready      (req_ready2),
        .lru_bits       (lru_bits2),
        .valid_bits     (valid_bits2),
        .rsp_valid      (rsp_valid2),
        .rsp_ready      (rsp_ready2),
        .victim         (victim2),
        .victim_invalid (victim_invalid2)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_req(input string tag, input logic [6:0] lru, input logic [7:0] vld,
                           input bit scramble, input int exp_lat, input int exp_victim,
                           input int exp_inv);
        int lat;
        req_valid  = 1'b1;
        lru_bits   = lru;
        valid_bits = vld;
        step();
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            if (scramble) begin
                lru_bits   = 7'($urandom);
                valid_bits = 8'($urandom);
            end
            step();
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_victim"}, int'(victim), exp_victim);
        check({tag, "_inv"}, int'(victim_invalid), exp_inv);
    endtask

    task automatic release_rsp(input string tag);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, "_rsp_done"}, int'(rsp_valid), 0);
        check({tag, "_ready_back"}, int'(req_ready), 1);
    endtask

    task automatic run_req2(input string tag, input logic [0:0] lru, input logic [1:0] vld,
                            input int exp_lat, input int exp_victim, input int exp_inv);
        int lat;
        req_valid2  = 1'b1;
        lru_bits2   = lru;
        valid_bits2 = vld;
        step();
        req_valid2 = 1'b0;
        lat = 0;
        while (!rsp_valid2 && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_victim"}, int'(victim2), exp_victim);
        check({tag, "_inv"}, int'(victim_invalid2), exp_inv);
        rsp_ready2 = 1'b1;
        step();
        rsp_ready2 = 1'b0;
        check({tag, "_ready_back"}, int'(req_ready2), 1);
    endtask

    initial begin
        bit saw_rsp;

        rst         = 1'b1;
        req_valid   = 1'b0;
        lru_bits    = '0;
        valid_bits  = '0;
        rsp_ready   = 1'b0;
        req_valid2  = 1'b0;
        lru_bits2   = '0;
        valid_bits2 = '0;
        rsp_ready2  = 1'b0;
        step();
        step();
        check("rst_req_ready", int'(req_ready), 1);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_victim", int'(victim), 0);
        check("rst_inv", int'(victim_invalid), 0);
        rst = 1'b0;
        step();

        // Tree walks: all-zero tree, path of way 7, bits 1 and 3 set.
        run_req("tree_zero", 7'b0000000, 8'hFF, 1'b0, 3, 7, 0);
        release_rsp("tree_zero");
        run_req("tree_way7", 7'b1000101, 8'hFF, 1'b0, 3, 3, 0);
        release_rsp("tree_way7");
        run_req("tree_b13", 7'b0001010, 8'hFF, 1'b0, 3, 7, 0);
        release_rsp("tree_b13");
        run_req("tree_ones", 7'b1111111, 8'hFF, 1'b0, 3, 0, 0);
        release_rsp("tree_ones");

        // Invalid-way priority.
        run_req("inv_way2", 7'b1010101, 8'b1110_1011, 1'b0, 0, 2, 1);
        release_rsp("inv_way2");
        run_req("inv_all", 7'b0000000, 8'h00, 1'b0, 0, 0, 1);
        release_rsp("inv_all");
        run_req("inv_top", 7'b0000000, 8'h7F, 1'b0, 0, 7, 1);
        release_rsp("inv_top");

        // Backpressure: hold DONE for 10 cycles with a competing request.
        run_req("stall", 7'b0000000, 8'hFF, 1'b0, 3, 7, 0);
        for (int i = 0; i < 10; i++) begin
            req_valid  = 1'b1;
            lru_bits   = 7'($urandom);
            valid_bits = 8'h00;
            step();
            check("stall_victim", int'(victim), 7);
            check("stall_req_ready", int'(req_ready), 0);
            check("stall_rsp_valid", int'(rsp_valid), 1);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("stall_release_ready", int'(req_ready), 1);
        check("stall_release_rsp", int'(rsp_valid), 0);
        run_req("after_stall", 7'b1000101, 8'hFF, 1'b0, 3, 3, 0);
        release_rsp("after_stall");

        // Reset while walking tree level 1.
        req_valid  = 1'b1;
        lru_bits   = 7'b0000000;
        valid_bits = 8'hFF;
        step();
        req_valid = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_req_ready", int'(req_ready), 1);
        check("midrst_rsp_valid", int'(rsp_valid), 0);
        check("midrst_victim", int'(victim), 0);
        check("midrst_inv", int'(victim_invalid), 0);
        step();
        step();
        rst = 1'b0;
        saw_rsp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rsp_valid) saw_rsp = 1'b1;
        end
        check("midrst_no_rsp", int'(saw_rsp), 0);
        run_req("post_rst", 7'b0000000, 8'hFF, 1'b0, 3, 7, 0);
        release_rsp("post_rst");

        // Inputs churn after accept; only captured values matter.
        run_req("scramble_tree", 7'b1000101, 8'hFF, 1'b1, 3, 3, 0);
        release_rsp("scramble_tree");
        run_req("scramble_inv", 7'b0000000, 8'b1110_1011, 1'b1, 0, 2, 1);
        release_rsp("scramble_inv");

        // Two-way configuration: single-node tree.
        run_req2("a2_lru0", 1'b0, 2'b11, 1, 1, 0);
        run_req2("a2_lru1", 1'b1, 2'b11, 1, 0, 0);
        run_req2("a2_inv1", 1'b0, 2'b01, 0, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
